aes_full_selftest: RTL and testbench
====================================

Name: aes_full_selftest

Overview:
- Board-level AES-128 self-test wrapper.
- The operator enters a 128-bit plaintext one byte at a time from eight slide switches, latching each byte with a push button.
- After 16 bytes the block encrypts the plaintext with a fixed key, decrypts the ciphertext, and drives one LED high when the round trip reproduces the plaintext.
- Sits between board I/O and the codebase's iterative AES-128 cipher/inverse-cipher cores.

Parameters:
- KEY, 128'h0, fixed AES-128 cipher key, used by both cores.
- BTN_SYNC_STAGES, 2, synchronizer depth on pushBtn (minimum 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- sw0..sw7  in  1 each  switch byte; sw0 is the MSB, sw7 the LSB.
- pushBtn  in  1  byte-latch button; asynchronous to clk.
- ledOut  out  1  pass indicator.

Behaviour:
- Internal registers:
  - dataIn[127:0]: plaintext.
  - outCounter[4:0]: bytes loaded, 0..16.
  - dataOutEncrypted[127:0].
  - dataOutDecrypted[127:0].
- Reset: synchronous, active-high. On reset:
  - dataIn, dataOutEncrypted, dataOutDecrypted and outCounter = 0.
  - ledOut = 0.
  - state = LOAD.
  - Synchronizer flops are cleared.
  - Reset in any state aborts the operation; core start pulses are not issued while rst=1.
- Button handling:
  - pushBtn passes through BTN_SYNC_STAGES flops, then a rising-edge detector.
  - One accepted press per 0->1 transition of the synchronized signal.
  - The press must be high for at least 1 clk period to be guaranteed seen.
- State LOAD:
  - On each accepted press: dataIn <= {dataIn[119:0], sw0..sw7}; outCounter += 1.
  - The first byte therefore ends in dataIn[127:120] and the 16th in [7:0].
  - The switches are sampled in the same cycle the edge is detected.
  - When outCounter becomes 16, go to ENC.
- State ENC:
  - Pulse enc_start for 1 cycle with din=dataIn and key=KEY.
  - Wait for enc_done, then capture dataOutEncrypted and go to DEC.
- State DEC:
  - Pulse dec_start with din=dataOutEncrypted.
  - On dec_done, capture dataOutDecrypted and go to DONE.
- State DONE:
  - ledOut <= (dataOutDecrypted == dataIn), registered, set 1 cycle after entering DONE.
  - The state holds until rst.
- Presses in ENC, DEC and DONE are ignored; dataIn and outCounter are frozen.
- ledOut is 0 in all states except DONE.
- Latency from the 16th accepted press to ledOut: BTN_SYNC_STAGES+1 cycles, plus enc latency, plus dec latency, plus 3 cycles.
- Total must be ≤ 40 cycles with the standard cores.

Optional Feature:
- Macro AES_DECRYPT_CHECK_EN.
- Defined: the inverse-cipher core is instantiated; DEC state is used; ledOut = round-trip compare as above.
- Undefined:
  - No decrypt core; ENC goes directly to DONE.
  - dataOutDecrypted stays 0.
  - ledOut = 1 in DONE, meaning "encryption complete".

Decomposition:
- Package aes_full_pkg holds:
  - state enum {LOAD, ENC, DEC, DONE};
  - BYTES_PER_BLOCK = 16;
  - typedef block_t = logic [127:0].
- Natural sub-module: aes_btn_sync (synchronizer plus rising-edge detector, one-cycle pulse output).
- Cipher work is done by the codebase's aes128_encrypt_core and aes128_decrypt_core:
  - ports: clk, rst, start, key[127:0], din[127:0], dout[127:0], done;
  - done is a 1-cycle pulse ≤ 12 cycles after start.
  - They are not reimplemented here.

Test Plan:
- Reset, then 16 presses with switches 8'h00 and KEY=0 -> outCounter=16, dataIn=0.
  - Then dataOutEncrypted=128'h66e94bd4ef8a2c3b884cfa59ca342b2e, dataOutDecrypted=0, ledOut=1 within 40 cycles.
- KEY=128'h000102030405060708090a0b0c0d0e0f, bytes 00,11,22,...,ff -> dataIn=128'h00112233445566778899aabbccddeeff.
  - Then dataOutEncrypted=128'h69c4e0d86a7b0430d8cdb78070b4c55a, ledOut=1.
- Press held high 10 cycles -> counted once; 15 presses -> outCounter=15, ledOut=0, no enc_start.
- 5 extra presses with switch value 8'hAA after DONE -> dataIn and outCounter unchanged, ledOut stays 1.
- rst asserted mid-ENC -> next cycle outCounter=0, dataIn=0, ledOut=0, state LOAD.
  - A fresh 16-byte load then completes normally.
- Build without AES_DECRYPT_CHECK_EN, zero vector -> ledOut=1 after encryption, dataOutDecrypted=0.

Source files
------------

// File: rtl/aes_full_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_full_pkg
// Purpose  : Shared types, constants and AES-128 arithmetic helpers for the
//            board self-test wrapper and its cipher cores.
// Revision : 1.0
// ============================================================================
package aes_full_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        ENC  = 2'd1,
        DEC  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int BYTES_PER_BLOCK = 16;

    typedef logic [127:0]       block_t;
    typedef logic [10:0][127:0] round_keys_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] s;
        logic [7:0] y;
        s = a;
        y = 8'h01;
        for (int k = 1; k < 8; k++) begin
            s = gmul(s, s);
            y = gmul(y, s);
        end
        return y;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    function automatic block_t sub_bytes(input block_t b, input logic inv);
        block_t o;
        for (int k = 0; k < 16; k++) begin
            o[8*k +: 8] = inv ? inv_sbox(b[8*k +: 8]) : sbox(b[8*k +: 8]);
        end
        return o;
    endfunction

    // Byte k of a block sits at [127-8k -: 8]; column c holds bytes 4c..4c+3.
    function automatic block_t shift_rows(input block_t b, input logic inv);
        block_t o;
        int     src;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inv ? 4 * ((c - r + 4) % 4) + r : 4 * ((c + r) % 4) + r;
                o[127 - 8*(4*c + r) -: 8] = b[127 - 8*src -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [7:0] mix_coef(input int idx, input logic inv);
        logic [7:0] c;
        case (idx)
            0:       c = inv ? 8'h0e : 8'h02;
            1:       c = inv ? 8'h0b : 8'h03;
            2:       c = inv ? 8'h0d : 8'h01;
            default: c = inv ? 8'h09 : 8'h01;
        endcase
        return c;
    endfunction

    function automatic block_t mix_columns(input block_t b, input logic inv);
        block_t     o;
        logic [7:0] acc;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                acc = '0;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gmul(mix_coef((j - i + 4) % 4, inv), b[127 - 8*(4*c + j) -: 8]);
                end
                o[127 - 8*(4*c + i) -: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic round_keys_t key_expand(input block_t key);
        logic [43:0][31:0] w;
        logic [31:0]       t;
        logic [7:0]        rcon;
        round_keys_t       rk;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rcon, 24'h0};
                rcon = xtime(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes128_decrypt_core.sv
`default_nettype none
// ============================================================================
// Module   : aes128_decrypt_core
// Purpose  : Iterative AES-128 inverse cipher, one round per cycle; done
//            pulses 10 cycles after start with the plaintext on dout.
// Revision : 1.0
// ============================================================================
module aes128_decrypt_core
    import aes_full_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] din,
    output logic [127:0] dout,
    output logic         done
);

    round_keys_t w_rk;
    block_t      w_isr;
    block_t      r_state;
    logic [3:0]  r_round;
    logic        r_busy;
    logic        r_done;

    assign w_rk  = key_expand(key);
    assign w_isr = sub_bytes(shift_rows(r_state, 1'b1), 1'b1);

    // Round keys are consumed in reverse: rk10 whitening, rk9..rk1, then rk0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= '0;
            r_round <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_state <= din ^ w_rk[10];
                r_round <= 4'd9;
                r_busy  <= 1'b1;
            end else if (r_busy) begin
                if (r_round == 4'd0) begin
                    r_state <= w_isr ^ w_rk[0];
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end else begin
                    r_state <= mix_columns(w_isr ^ w_rk[r_round], 1'b1);
                    r_round <= r_round - 4'd1;
                end
            end
        end
    end

    assign dout = r_state;
    assign done = r_done;

endmodule
`default_nettype wire

// File: rtl/aes128_encrypt_core.sv
`default_nettype none
// ============================================================================
// Module   : aes128_encrypt_core
// Purpose  : Iterative AES-128 cipher, one round per cycle; done pulses
//            10 cycles after start with the ciphertext on dout.
// Revision : 1.0
// ============================================================================
module aes128_encrypt_core
    import aes_full_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] din,
    output logic [127:0] dout,
    output logic         done
);

    round_keys_t w_rk;
    block_t      w_sr;
    block_t      r_state;
    logic [3:0]  r_round;
    logic        r_busy;
    logic        r_done;

    assign w_rk = key_expand(key);
    assign w_sr = shift_rows(sub_bytes(r_state, 1'b0), 1'b0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= '0;
            r_round <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_state <= din ^ w_rk[0];
                r_round <= 4'd1;
                r_busy  <= 1'b1;
            end else if (r_busy) begin
                if (r_round == 4'd10) begin
                    r_state <= w_sr ^ w_rk[10];
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end else begin
                    r_state <= mix_columns(w_sr, 1'b0) ^ w_rk[r_round];
                    r_round <= r_round + 4'd1;
                end
            end
        end
    end

    assign dout = r_state;
    assign done = r_done;

endmodule
`default_nettype wire

// File: rtl/aes_btn_sync.sv
`default_nettype none
// ============================================================================
// Module   : aes_btn_sync
// Purpose  : Push-button synchronizer with rising-edge detector; emits a
//            one-cycle pulse per 0->1 transition of the synchronized input.
// Revision : 1.0
// ============================================================================
module aes_btn_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_pulse
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_btn};
            r_prev <= r_sync[STAGES-1];
        end
    end

    // Combinational so the consumer samples the switches in the detect cycle.
    assign o_pulse = r_sync[STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/aes_full_selftest.sv
`default_nettype none
// ============================================================================
// Module   : aes_full_selftest
// Purpose  : Board AES-128 self-test: loads 16 switch bytes, encrypts with a
//            fixed key and (with AES_DECRYPT_CHECK_EN) checks the round trip.
// Revision : 1.0
// ============================================================================
module aes_full_selftest
    import aes_full_pkg::*;
#(
    parameter logic [127:0] KEY             = 128'h0,
    parameter int           BTN_SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sw0,
    input  logic sw1,
    input  logic sw2,
    input  logic sw3,
    input  logic sw4,
    input  logic sw5,
    input  logic sw6,
    input  logic sw7,
    input  logic pushBtn,
    output logic ledOut
);

    block_t     r_data_in;
    block_t     r_data_enc;
    block_t     r_data_dec;
    logic [4:0] r_out_counter;
    state_t     r_state;
    logic       r_enc_start;
    logic       w_press;
    logic [7:0] w_sw;
    block_t     w_enc_dout;
    logic       w_enc_done;

    assign w_sw = {sw0, sw1, sw2, sw3, sw4, sw5, sw6, sw7};

    aes_btn_sync #(
        .STAGES (BTN_SYNC_STAGES)
    ) u_btn (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (pushBtn),
        .o_pulse (w_press)
    );

    aes128_encrypt_core u_enc (
        .clk   (clk),
        .rst   (rst),
        .start (r_enc_start),
        .key   (KEY),
        .din   (r_data_in),
        .dout  (w_enc_dout),
        .done  (w_enc_done)
    );

`ifdef AES_DECRYPT_CHECK_EN
    logic   r_dec_start;
    block_t w_dec_dout;
    logic   w_dec_done;

    aes128_decrypt_core u_dec (
        .clk   (clk),
        .rst   (rst),
        .start (r_dec_start),
        .key   (KEY),
        .din   (r_data_enc),
        .dout  (w_dec_dout),
        .done  (w_dec_done)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_in     <= '0;
            r_data_enc    <= '0;
            r_data_dec    <= '0;
            r_out_counter <= 5'd0;
            r_state       <= LOAD;
            r_enc_start   <= 1'b0;
            ledOut        <= 1'b0;
`ifdef AES_DECRYPT_CHECK_EN
            r_dec_start   <= 1'b0;
`endif
        end else begin
            r_enc_start <= 1'b0;
            ledOut      <= 1'b0;
`ifdef AES_DECRYPT_CHECK_EN
            r_dec_start <= 1'b0;
`endif
            case (r_state)
                LOAD: begin
                    if (w_press) begin
                        r_data_in     <= {r_data_in[119:0], w_sw};
                        r_out_counter <= r_out_counter + 5'd1;
                        if (r_out_counter == 5'(BYTES_PER_BLOCK - 1)) begin
                            r_state     <= ENC;
                            r_enc_start <= 1'b1;
                        end
                    end
                end
                ENC: begin
                    if (w_enc_done) begin
                        r_data_enc <= w_enc_dout;
`ifdef AES_DECRYPT_CHECK_EN
                        r_dec_start <= 1'b1;
                        r_state     <= DEC;
`else
                        r_state     <= DONE;
`endif
                    end
                end
`ifdef AES_DECRYPT_CHECK_EN
                DEC: begin
                    if (w_dec_done) begin
                        r_data_dec <= w_dec_dout;
                        r_state    <= DONE;
                    end
                end
                DONE: ledOut <= (r_data_dec == r_data_in);
`else
                // Without the inverse core the decrypted block stays zero, so
                // this lights the LED as a plain "encryption complete" flag.
                DONE: ledOut <= ~|r_data_dec;
`endif
                default: r_state <= LOAD;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_full_selftest.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_full_selftest
// Purpose  : Self-checking bench for aes_full_selftest (two key instances).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_aes_full_selftest;
    import aes_full_pkg::*;

    localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1;
    logic       rst_b = 1'b1;
    logic       btn_a = 1'b0;
    logic       btn_b = 1'b0;
    logic       led_a;
    logic       led_b;
    logic [7:0] sw = 8'h00;
    int         checks = 0;
    int         failures = 0;
    int         enc_pulses_a = 0;

    always #5 clk = ~clk;

    aes_full_selftest #(.KEY(128'h0), .BTN_SYNC_STAGES(2)) dut0 (
        .clk(clk), .rst(rst_a),
        .sw0(sw[7]), .sw1(sw[6]), .sw2(sw[5]), .sw3(sw[4]),
        .sw4(sw[3]), .sw5(sw[2]), .sw6(sw[1]), .sw7(sw[0]),
        .pushBtn(btn_a), .ledOut(led_a)
    );

    aes_full_selftest #(.KEY(KEY_B), .BTN_SYNC_STAGES(2)) dut1 (
        .clk(clk), .rst(rst_b),
        .sw0(sw[7]), .sw1(sw[6]), .sw2(sw[5]), .sw3(sw[4]),
        .sw4(sw[3]), .sw5(sw[2]), .sw6(sw[1]), .sw7(sw[0]),
        .pushBtn(btn_b), .ledOut(led_b)
    );

    always @(negedge clk) if (dut0.r_enc_start) enc_pulses_a++;

    function automatic logic [127:0] get_din(input bit sel);
        return sel ? dut1.r_data_in : dut0.r_data_in;
    endfunction
    function automatic logic [127:0] get_enc(input bit sel);
        return sel ? dut1.r_data_enc : dut0.r_data_enc;
    endfunction
    function automatic logic [127:0] get_dec(input bit sel);
        return sel ? dut1.r_data_dec : dut0.r_data_dec;
    endfunction
    function automatic logic [4:0] get_cnt(input bit sel);
        return sel ? dut1.r_out_counter : dut0.r_out_counter;
    endfunction
    function automatic state_t get_state(input bit sel);
        return sel ? dut1.r_state : dut0.r_state;
    endfunction
    function automatic logic get_led(input bit sel);
        return sel ? led_b : led_a;
    endfunction

    // Round-trip expectation: decrypted block equals plaintext, or stays 0.
    function automatic logic [127:0] exp_dec(input logic [127:0] plain);
`ifdef AES_DECRYPT_CHECK_EN
        return plain;
`else
        return 128'h0 & plain;
`endif
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_reset(input bit sel);
        @(negedge clk);
        if (sel) rst_b = 1'b1; else rst_a = 1'b1;
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
    endtask

    task automatic press(input bit sel, input logic [7:0] val, input int hold);
        sw = val;
        @(negedge clk);
        if (sel) btn_b = 1'b1; else btn_a = 1'b1;
        repeat (hold) @(negedge clk);
        btn_a = 1'b0;
        btn_b = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // 16th press waits (bounded) for the LED and reports cycles since the press.
    task automatic load_block(input bit sel, input logic [15:0][7:0] b, input int hold, output int lat);
        for (int i = 0; i < 15; i++) press(sel, b[i], hold);
        sw = b[15];
        @(negedge clk);
        if (sel) btn_b = 1'b1; else btn_a = 1'b1;
        lat = 0;
        while (get_led(sel) !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
            if (lat == hold) begin btn_a = 1'b0; btn_b = 1'b0; end
        end
        btn_a = 1'b0;
        btn_b = 1'b0;
        check("latency_le_40", 128'(lat <= 40), 128'd1);
    endtask

    typedef struct {
        bit           sel;
        logic [7:0]   base;
        logic [7:0]   step;
        logic [127:0] exp_din;
        logic [127:0] exp_enc;
    } vec_t;

    vec_t             vecs [2];
    logic [15:0][7:0] bytes_v;
    logic [7:0]       q [$];
    logic [127:0]     model;
    int               lat;
    bit               sel;
    int               hold;
    int               waited;

    initial begin
        vecs[0] = '{1'b0, 8'h00, 8'h00, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        vecs[1] = '{1'b1, 8'h00, 8'h11, 128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a};

        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        check("reset_cnt", 128'(get_cnt(0)), 128'd0);
        check("reset_din", get_din(0), 128'h0);
        check("reset_enc", get_enc(0), 128'h0);
        check("reset_led", 128'(led_a), 128'd0);
        check("reset_state", 128'(get_state(0)), 128'(LOAD));

        // Known-answer vectors
        for (int v = 0; v < 2; v++) begin
            do_reset(vecs[v].sel);
            for (int i = 0; i < 16; i++) bytes_v[i] = vecs[v].base + 8'(i) * vecs[v].step;
            load_block(vecs[v].sel, bytes_v, 1, lat);
            check("kat_din", get_din(vecs[v].sel), vecs[v].exp_din);
            check("kat_cnt", 128'(get_cnt(vecs[v].sel)), 128'd16);
            check("kat_enc", get_enc(vecs[v].sel), vecs[v].exp_enc);
            check("kat_dec", get_dec(vecs[v].sel), exp_dec(vecs[v].exp_din));
            check("kat_led", 128'(get_led(vecs[v].sel)), 128'd1);
            check("kat_state", 128'(get_state(vecs[v].sel)), 128'(DONE));
        end

        // Random plaintexts with random press lengths
        for (int t = 0; t < 4; t++) begin
            sel  = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 10);
            q.delete();
            for (int i = 0; i < 16; i++) begin
                q.push_back(8'($urandom));
                bytes_v[i] = q[i];
            end
            model = '0;
            for (int i = 0; i < 16; i++) model[127 - 8*i -: 8] = q[i];
            do_reset(sel);
            load_block(sel, bytes_v, hold, lat);
            check("rnd_din", get_din(sel), model);
            check("rnd_cnt", 128'(get_cnt(sel)), 128'd16);
            check("rnd_dec", get_dec(sel), exp_dec(model));
            check("rnd_led", 128'(get_led(sel)), 128'd1);
        end

        // Long press counts once; 15 presses never start the cipher
        do_reset(0);
        enc_pulses_a = 0;
        q.delete();
        press(0, 8'h5a, 10);
        q.push_back(8'h5a);
        check("held_cnt", 128'(get_cnt(0)), 128'd1);
        check("held_din", get_din(0), 128'h5a);
        for (int i = 1; i < 15; i++) begin
            press(0, 8'(i * 7 + 3), 1);
            q.push_back(8'(i * 7 + 3));
        end
        repeat (20) @(negedge clk);
        check("p15_cnt", 128'(get_cnt(0)), 128'd15);
        check("p15_led", 128'(led_a), 128'd0);
        check("p15_state", 128'(get_state(0)), 128'(LOAD));
        check("p15_no_start", 128'(enc_pulses_a), 128'd0);

        press(0, 8'hc3, 1);
        q.push_back(8'hc3);
        waited = 0;
        while (led_a !== 1'b1 && waited < 40) begin @(negedge clk); waited++; end
        model = '0;
        for (int i = 0; i < 16; i++) model[127 - 8*i -: 8] = q[i];
        check("p16_led", 128'(led_a), 128'd1);
        check("p16_din", get_din(0), model);
        check("p16_one_start", 128'(enc_pulses_a), 128'd1);

        // Presses after DONE are ignored
        for (int i = 0; i < 5; i++) press(0, 8'haa, 1);
        check("post_din", get_din(0), model);
        check("post_cnt", 128'(get_cnt(0)), 128'd16);
        check("post_led", 128'(led_a), 128'd1);
        check("post_state", 128'(get_state(0)), 128'(DONE));

        // Reset while encrypting
        do_reset(0);
        for (int i = 0; i < 15; i++) press(0, 8'h00, 1);
        sw = 8'h00;
        @(negedge clk);
        btn_a = 1'b1;
        waited = 0;
        while (get_state(0) != ENC && waited < 10) begin
            @(negedge clk);
            waited++;
            btn_a = 1'b0;
        end
        btn_a = 1'b0;
        check("mid_reached_enc", 128'(get_state(0)), 128'(ENC));
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        check("mid_cnt", 128'(get_cnt(0)), 128'd0);
        check("mid_din", get_din(0), 128'h0);
        check("mid_led", 128'(led_a), 128'd0);
        check("mid_state", 128'(get_state(0)), 128'(LOAD));
        repeat (20) @(negedge clk);
        check("mid_stays_load", 128'(get_state(0)), 128'(LOAD));
        check("mid_enc_clear", get_enc(0), 128'h0);
        for (int i = 0; i < 16; i++) bytes_v[i] = 8'h00;
        load_block(0, bytes_v, 2, lat);
        check("mid_reload_enc", get_enc(0), 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
        check("mid_reload_dec", get_dec(0), exp_dec(128'h0));
        check("mid_reload_led", 128'(led_a), 128'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
